// File: rtl/vx_buffer_pkg.sv
// Shared types and helpers for the vx buffer family.
//   vx_clog2_min1 : pointer width helper, never returns less than 1 bit
//   PERF_CNTW     : width of the optional performance counters
//   perf_cnt_t    : performance counter type
package vx_buffer_pkg;

  localparam int unsigned PERF_CNTW = 32;

  typedef logic [PERF_CNTW-1:0] perf_cnt_t;

  // max(1, $clog2(n)) so that a 1-entry range still has a 1-bit pointer
  function automatic int unsigned vx_clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vx_elastic_queue_if.sv
// Handshake bundle for vx_elastic_queue.
//   upstream   : valid_in, data_in (to queue), ready_in (from queue)
//   downstream : valid_out, data_out (from queue), ready_out (to queue)
//   status     : count, full, empty, alm_full (from queue)
// modport slave is the queue side, modport master the surrounding pipeline.
interface vx_elastic_queue_if #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic             valid_in;
  logic             ready_in;
  logic [DATAW-1:0] data_in;
  logic             valid_out;
  logic             ready_out;
  logic [DATAW-1:0] data_out;
  logic [CNTW-1:0]  count;
  logic             full;
  logic             empty;
  logic             alm_full;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, count, full, empty, alm_full
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, count, full, empty, alm_full
  );

endinterface

// File: rtl/vx_wrap_counter.sv
// Modulo-MAX pointer: advances on en_i, wraps MAX-1 -> 0.
//   clk, reset : clock, asynchronous active-high reset (clears to 0)
//   en_i       : advance enable
//   cnt_o      : current pointer value (registered)
module vx_wrap_counter
  import vx_buffer_pkg::*;
#(
  parameter  int unsigned MAX = 4,
  localparam int unsigned W   = vx_clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next pointer value with explicit wrap (MAX need not be a power of two)
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == W'(MAX - 1)) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vx_elastic_queue.sv
// N-entry elastic buffer whose ready_in depends only on registered state,
// breaking the ready_out -> ready_in combinational path.
//   clk, reset      : clock, asynchronous active-high reset
//   q (slave)       : valid_in/ready_in/data_in upstream, valid_out/ready_out/
//                     data_out downstream, count/full/empty/alm_full status
//   perf_stalls     : (VX_ELASTIC_QUEUE_PERF_EN) cycles with valid_out & ~ready_out
//   perf_full       : (VX_ELASTIC_QUEUE_PERF_EN) cycles with full & valid_in
// PASSTHRU != 0 reduces the block to wires.
module vx_elastic_queue
  import vx_buffer_pkg::*;
#(
  parameter int unsigned DATAW    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ALM_FULL = DEPTH - 1,
  parameter int unsigned PASSTHRU = 0
) (
  input  logic              clk,
  input  logic              reset,
  vx_elastic_queue_if.slave q
`ifdef VX_ELASTIC_QUEUE_PERF_EN
  ,
  output perf_cnt_t         perf_stalls,
  output perf_cnt_t         perf_full
`endif
);

  localparam int unsigned PTRW = vx_clog2_min1(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  if (PASSTHRU != 0) begin : g_pass

    assign q.ready_in  = q.ready_out;
    assign q.valid_out = q.valid_in;
    assign q.data_out  = q.data_in;
    assign q.count     = '0;
    assign q.full      = 1'b0;
    assign q.empty     = 1'b1;
    assign q.alm_full  = 1'b0;
`ifdef VX_ELASTIC_QUEUE_PERF_EN
    assign perf_stalls = '0;
    assign perf_full   = '0;
`endif

  end else begin : g_queue

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;

    // status decoded from the occupancy register only
    assign full_c  = (count_q == CNTW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign push_c  = q.valid_in & ~full_c;
    assign pop_c   = q.ready_out & ~empty_c;

    vx_wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .en_i  (push_c),
      .cnt_o (wr_ptr)
    );

    vx_wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .en_i  (pop_c),
      .cnt_o (rd_ptr)
    );

    // occupancy: push-only +1, pop-only -1, otherwise hold
    always_comb begin
      count_d = count_q;
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
    end

    // storage is cleared on reset so data_out reads 0 while empty after reset
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push_c) begin
        mem_q[wr_ptr] <= q.data_in;
      end
    end

    assign q.ready_in  = ~full_c;
    assign q.valid_out = ~empty_c;
    assign q.data_out  = mem_q[rd_ptr];
    assign q.count     = count_q;
    assign q.full      = full_c;
    assign q.empty     = empty_c;
    assign q.alm_full  = (count_q >= CNTW'(ALM_FULL));

`ifdef VX_ELASTIC_QUEUE_PERF_EN
    perf_cnt_t stalls_q;
    perf_cnt_t full_cnt_q;

    // saturating event counters
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stalls_q   <= '0;
        full_cnt_q <= '0;
      end else begin
        if (~empty_c && ~q.ready_out && (stalls_q != '1))
          stalls_q <= stalls_q + PERF_CNTW'(1);
        if (full_c && q.valid_in && (full_cnt_q != '1))
          full_cnt_q <= full_cnt_q + PERF_CNTW'(1);
      end
    end

    assign perf_stalls = stalls_q;
    assign perf_full   = full_cnt_q;
`endif

    a_depth_min: assert property (@(posedge clk) DEPTH >= 2)
      else $error("DEPTH must be at least 2");
    a_alm_range: assert property (@(posedge clk) (ALM_FULL >= 1) && (ALM_FULL <= DEPTH))
      else $error("ALM_FULL out of range");
    a_cnt_max: assert property (@(posedge clk) disable iff (reset) count_q <= CNTW'(DEPTH))
      else $error("occupancy exceeds DEPTH");
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) full_c |-> !push_c)
      else $error("push while full");

  end

endmodule

// File: tb/tb_vx_elastic_queue.sv
module tb_vx_elastic_queue;

  localparam int unsigned DATAW = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ALMF  = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vx_elastic_queue_if #(.DATAW(DATAW), .DEPTH(DEPTH)) qif ();

`ifdef VX_ELASTIC_QUEUE_PERF_EN
  logic [31:0] perf_stalls;
  logic [31:0] perf_full;
`endif

  vx_elastic_queue #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ALM_FULL(ALMF), .PASSTHRU(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif)
`ifdef VX_ELASTIC_QUEUE_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_full   (perf_full)
`endif
  );

  typedef struct {
    logic       vi;
    logic [7:0] di;
    logic       ro;
    int         cnt;
    logic       chk_d;
    logic [7:0] dout;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] sb [$];
  int         checks = 0;
  int         errors = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // status outputs against a given expected occupancy
  task automatic check_status(input string tag, input int cnt);
    check({tag, " count"},     32'(qif.count),     32'(cnt));
    check({tag, " valid_out"}, 32'(qif.valid_out), 32'(cnt != 0));
    check({tag, " ready_in"},  32'(qif.ready_in),  32'(cnt != int'(DEPTH)));
    check({tag, " full"},      32'(qif.full),      32'(cnt == int'(DEPTH)));
    check({tag, " empty"},     32'(qif.empty),     32'(cnt == 0));
    check({tag, " alm_full"},  32'(qif.alm_full),  32'(cnt >= int'(ALMF)));
  endtask

  // drive one cycle's inputs after a negedge, score the handshake, advance to next negedge
  task automatic cycle(input logic vi, input logic [7:0] di, input logic ro, output logic acc);
    logic [7:0] exp_d;
    qif.valid_in  = vi;
    qif.data_in   = di;
    qif.ready_out = ro;
    #1;
    if (stall_prev) begin
      check("stall valid_out held", 32'(qif.valid_out), 32'(1));
      check("stall data_out held",  32'(qif.data_out),  32'(stall_data));
    end
    stall_prev = qif.valid_out & ~ro;
    stall_data = qif.data_out;
    if (qif.valid_out && ro) begin
      if (sb.size() == 0) begin
        check("unexpected pop", 32'(1), 32'(0));
      end else begin
        exp_d = sb.pop_front();
        check("scoreboard data", 32'(qif.data_out), 32'(exp_d));
      end
    end
    acc = vi & qif.ready_in;
    if (acc) sb.push_back(di);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   cyc;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 4, 1'b1, 8'h11};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 4, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 8'h66, 1'b1, 3, 1'b1, 8'h22};
    tbl[6]  = '{1'b1, 8'h77, 1'b1, 3, 1'b1, 8'h33};
    tbl[7]  = '{1'b1, 8'h88, 1'b1, 3, 1'b1, 8'h44};
    tbl[8]  = '{1'b1, 8'h99, 1'b1, 3, 1'b1, 8'h77};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h88};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h99};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    reset         = 1'b0;
    qif.valid_in  = 1'b0;
    qif.data_in   = '0;
    qif.ready_out = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_status("reset", 0);
    check("reset data_out", 32'(qif.data_out), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // fill, drain at full, and drain to empty
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].vi, tbl[i].di, tbl[i].ro, acc);
      check_status($sformatf("vec%0d", i), tbl[i].cnt);
      if (tbl[i].chk_d) check($sformatf("vec%0d data_out", i), 32'(qif.data_out), 32'(tbl[i].dout));
    end
    check("table scoreboard drained", 32'(sb.size()), 32'(0));

    // streaming at one item per cycle across pointer wrap
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 8'(k), 1'b1, acc);
      check($sformatf("wrap accept %0d", k), 32'(acc), 32'(1));
      check($sformatf("wrap count %0d", k), 32'(qif.count), 32'(1));
      check($sformatf("wrap head %0d", k), 32'(qif.data_out), 32'(k));
    end
    cycle(1'b0, 8'h00, 1'b1, acc);
    check("wrap final count", 32'(qif.count), 32'(0));
    check("wrap scoreboard drained", 32'(sb.size()), 32'(0));

    // random backpressure, bounded
    sent = 0;
    cyc  = 0;
    while ((sent < 200 || sb.size() != 0) && cyc < 4000) begin
      cycle((sent < 200) && ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
      cyc++;
    end
    check("random items sent", 32'(sent), 32'(200));
    check("random scoreboard drained", 32'(sb.size()), 32'(0));
    cycle(1'b0, 8'h00, 1'b0, acc);
    check_status("random idle", 0);

    // reset in the middle of operation
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'hA0 + 8'(k), 1'b0, acc);
    check_status("pre-reset", 3);
    qif.valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_status("mid reset", 0);
    check("mid reset data_out", 32'(qif.data_out), 32'(0));
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 8'h55, 1'b0, acc);
    check_status("post reset push", 1);
    check("post reset data_out", 32'(qif.data_out), 32'(8'h55));

`ifdef VX_ELASTIC_QUEUE_PERF_EN
    reset = 1'b1;
    #1;
    check("perf_stalls reset", perf_stalls, 32'(0));
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 8'hAA, 1'b0, acc);
    for (int k = 0; k < 7; k++) cycle(1'b0, 8'h00, 1'b0, acc);
    check("perf_stalls 7", perf_stalls, 32'd7);
    dut.g_queue.stalls_q = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, acc);
    check("perf_stalls saturate", perf_stalls, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
